// File: rtl/vend_ctrl.sv
// Coin-handling controller: queues coin events, tracks credit in half-units,
// and sequences the dispense and change outputs.
module vend_ctrl #(
    parameter int unsigned PRICE       = 3,
    parameter int unsigned DISP_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       coin_half,
    input  logic       coin_one,
    input  logic       cancel,
    output logic [3:0] credit,
    output logic       dispense,
    output logic       change,
    output logic       busy,
    output logic       coin_reject,
    output logic       fifo_full
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCUM  = 3'd1;
    localparam logic [2:0] S_VEND   = 3'd2;
    localparam logic [2:0] S_CHANGE = 3'd3;
    localparam logic [2:0] S_REFUND = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic          dispense_q, dispense_d;
    logic          change_q, change_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          reject_q, reject_d;

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;

    logic          push_req_c, push_ok_c, pop_c;
    logic [1:0]    push_val_c;

    // Push side: coin_one wins a same-cycle collision, a full FIFO drops the event
    always_comb begin
        push_req_c = coin_one | coin_half;
        push_val_c = coin_one ? 2'd2 : 2'd1;
        push_ok_c  = push_req_c & ~full_q;
        reject_d   = (coin_one & coin_half) | (push_req_c & full_q);
        count_d    = count_q + CW'(push_ok_c) - CW'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_val_c;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            reject_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q  <= count_d;
            full_q   <= (count_d == CW'(FIFO_DEPTH));
            empty_q  <= (count_d == '0);
            reject_q <= reject_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        dispense_d = dispense_q;
        change_d   = 1'b0;
        timer_d    = timer_q;
        pop_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop_c    = 1'b1;
                    credit_d = credit_q + 4'(mem_q[rd_ptr_q]);
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!empty_q) begin
                    pop_c    = 1'b1;
                    credit_d = credit_q + 4'(mem_q[rd_ptr_q]);
                end
                if (credit_d >= 4'(PRICE)) begin
                    state_d = S_VEND;
                end else if (empty_q && cancel && (credit_q != 4'd0)) begin
                    state_d = S_REFUND;
                end
            end
            S_VEND: begin
                // dispense low inside VEND marks the entry cycle
                if (!dispense_q) begin
                    credit_d   = credit_q - 4'(PRICE);
                    dispense_d = 1'b1;
                    timer_d    = TW'(DISP_CYCLES - 1);
                end else if (timer_q == '0) begin
                    dispense_d = 1'b0;
                    state_d    = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_CHANGE, S_REFUND: begin
                if (!change_q) begin
                    if (credit_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        change_d = 1'b1;
                        credit_d = credit_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            credit_q   <= 4'd0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            change_q   <= change_d;
            timer_q    <= timer_d;
        end
    end

    assign busy        = (state_q == S_VEND) || (state_q == S_CHANGE) || (state_q == S_REFUND);
    assign credit      = credit_q;
    assign dispense    = dispense_q;
    assign change      = change_q;
    assign coin_reject = reject_q;
    assign fifo_full   = full_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: credit changes are scored against an expectation queue,
// pulse counts and flags are checked per scenario.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       coin_half = 1'b0;
    logic       coin_one = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] credit;
    logic       dispense;
    logic       change;
    logic       busy;
    logic       coin_reject;
    logic       fifo_full;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev_credit = 4'd0;
    logic [3:0] mon_exp;
    int         disp_cnt = 0;
    int         chg_cnt = 0;
    int         rej_cnt = 0;

    vend_ctrl #(.PRICE(3), .DISP_CYCLES(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .coin_half  (coin_half),
        .coin_one   (coin_one),
        .cancel     (cancel),
        .credit     (credit),
        .dispense   (dispense),
        .change     (change),
        .busy       (busy),
        .coin_reject(coin_reject),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every credit change must match the next queued value
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (credit !== prev_credit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL credit_unexpected got %0d expected no change from %0d", credit, prev_credit);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (credit !== mon_exp) begin
                        errors++;
                        $display("FAIL credit_seq got %0d expected %0d", credit, mon_exp);
                    end
                end
                prev_credit = credit;
            end
            if (dispense === 1'b1) disp_cnt++;
            if (change === 1'b1) chg_cnt++;
            if (coin_reject === 1'b1) rej_cnt++;
        end
    endtask

    task automatic pulse(input logic one, input logic half, input logic canc);
        @(posedge clk);
        #1;
        coin_one  = one;
        coin_half = half;
        cancel    = canc;
        @(posedge clk);
        #1;
        coin_one  = 1'b0;
        coin_half = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d busy=%b expected pending=0 busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic wait_dispense(input string name);
        int n;
        n = 0;
        while (dispense !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dispense !== 1'b1) begin
            errors++;
            $display("FAIL %s_dispense_timeout got %b expected 1", name, dispense);
        end
    endtask

    task automatic wait_credit(input logic [3:0] val, input string name);
        int n;
        n = 0;
        while (credit !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (credit !== val) begin
            errors++;
            $display("FAIL %s_credit_timeout got %0d expected %0d", name, credit, val);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (credit !== 4'd0 || dispense !== 1'b0 || change !== 1'b0 || busy !== 1'b0 ||
            coin_reject !== 1'b0 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got credit=%0d disp=%b chg=%b busy=%b rej=%b full=%b expected all 0",
                     credit, dispense, change, busy, coin_reject, fifo_full);
        end
        @(posedge clk);
        #1 clr = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_vend();
        int chg0;
        chg0 = chg_cnt;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd1);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        wait_dispense("rst_vend");
        repeat (2) @(negedge clk);
        exp_q.push_back(4'd0);
        #2 clr = 1'b0;
        #1;
        checks++;
        if (dispense !== 1'b0 || change !== 1'b0 || credit !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_vend_immediate got disp=%b chg=%b credit=%0d busy=%b expected 0 0 0 0",
                     dispense, change, credit, busy);
        end
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (credit !== 4'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_vend_after_release got credit=%0d busy=%b expected 0 0", credit, busy);
            end
        end
        wait_drain("rst_vend");
        checks++;
        if (chg_cnt - chg0 !== 0) begin
            errors++;
            $display("FAIL rst_vend_change got %0d expected 0", chg_cnt - chg0);
        end
    endtask

    task automatic test_half_x3();
        int d0;
        int c0;
        d0 = disp_cnt;
        c0 = chg_cnt;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            repeat (3) @(posedge clk);
        end
        wait_drain("half_x3");
        checks++;
        if (disp_cnt - d0 !== 8 || chg_cnt - c0 !== 0 || credit !== 4'd0) begin
            errors++;
            $display("FAIL half_x3_result got disp=%0d chg=%0d credit=%0d expected 8 0 0",
                     disp_cnt - d0, chg_cnt - c0, credit);
        end
    endtask

    task automatic test_one_x2();
        int d0;
        int c0;
        d0 = disp_cnt;
        c0 = chg_cnt;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        wait_drain("one_x2");
        checks++;
        if (disp_cnt - d0 !== 8 || chg_cnt - c0 !== 1 || credit !== 4'd0) begin
            errors++;
            $display("FAIL one_x2_result got disp=%0d chg=%0d credit=%0d expected 8 1 0",
                     disp_cnt - d0, chg_cnt - c0, credit);
        end
    endtask

    task automatic test_cancel();
        int d0;
        int c0;
        d0 = disp_cnt;
        c0 = chg_cnt;
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || credit !== 4'd0) begin
            errors++;
            $display("FAIL cancel_idle got busy=%b credit=%0d expected 0 0", busy, credit);
        end
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_credit(4'd1, "cancel");
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_refund_busy got %b expected 1", busy);
        end
        wait_drain("cancel");
        checks++;
        if (disp_cnt - d0 !== 0 || chg_cnt - c0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_result got disp=%0d chg=%0d busy=%b expected 0 1 0",
                     disp_cnt - d0, chg_cnt - c0, busy);
        end
    endtask

    task automatic test_fifo_full();
        int d0;
        int c0;
        int r0;
        d0 = disp_cnt;
        c0 = chg_cnt;
        r0 = rej_cnt;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        wait_dispense("fifo_full");
        @(posedge clk);
        #1 coin_half = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                checks++;
                if (fifo_full !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_full_after3 got %b expected 0", fifo_full);
                end
            end
            if (i == 4) begin
                checks++;
                if (fifo_full !== 1'b1 || coin_reject !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_full_after4 got full=%b rej=%b expected 1 0", fifo_full, coin_reject);
                end
            end
            if (i == 5) begin
                coin_half = 1'b0;
                checks++;
                if (coin_reject !== 1'b1 || dispense !== 1'b1) begin
                    errors++;
                    $display("FAIL fifo_full_reject5 got rej=%b disp=%b expected 1 1", coin_reject, dispense);
                end
            end
        end
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        wait_drain("fifo_full");
        checks++;
        if (disp_cnt - d0 !== 16 || rej_cnt - r0 !== 1 || fifo_full !== 1'b0 || credit !== 4'd1) begin
            errors++;
            $display("FAIL fifo_full_result got disp=%0d rej=%0d full=%b credit=%0d expected 16 1 0 1",
                     disp_cnt - d0, rej_cnt - r0, fifo_full, credit);
        end
        exp_q.push_back(4'd0);
        pulse(1'b0, 1'b0, 1'b1);
        wait_drain("fifo_full_refund");
        checks++;
        if (chg_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL fifo_full_change got %0d expected 1", chg_cnt - c0);
        end
    endtask

    task automatic test_same_cycle();
        int c0;
        int r0;
        c0 = chg_cnt;
        r0 = rej_cnt;
        exp_q.push_back(4'd2);
        @(posedge clk);
        #1;
        coin_half = 1'b1;
        coin_one  = 1'b1;
        @(posedge clk);
        #1;
        coin_half = 1'b0;
        coin_one  = 1'b0;
        checks++;
        if (coin_reject !== 1'b1 || credit !== 4'd0) begin
            errors++;
            $display("FAIL same_cycle_reject got rej=%b credit=%0d expected 1 0", coin_reject, credit);
        end
        @(posedge clk);
        #1;
        checks++;
        if (credit !== 4'd2 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_latency got credit=%0d rej=%b expected 2 0", credit, coin_reject);
        end
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
        pulse(1'b0, 1'b0, 1'b1);
        wait_drain("same_cycle");
        checks++;
        if (chg_cnt - c0 !== 2 || rej_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL same_cycle_result got chg=%0d rej=%0d expected 2 1", chg_cnt - c0, rej_cnt - r0);
        end
    endtask

    initial begin
        #1 clr = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_reset_in_vend();
        test_half_x3();
        test_one_x2();
        test_cancel();
        test_fifo_full();
        test_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
